instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the RISCV32i processor. Holds the program counter, fetches one instruction word at a time from instruction memory over a request/ready/valid handshake, and presents the latched instruction and its decoded fields (op, funct3, funct7) to the control unit. The block consumes PCSrc and the extended immediate from the decode/execute side to select the next PC, and holds each instruction for one retire cycle unless stalled.

## Interface

- RESET_PC, 32'h0000_0000: PC value loaded on reset (word aligned).
- NOP_INSTR, 32'h0000_0013: instruction register value on reset and after a fault (addi x0,x0,0).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  32  fetch address; equals PC while imem_req=1.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- PCSrc  in  1  take branch/jump target (from control unit).
- ImmExt  in  32  sign-extended offset for target = PC + ImmExt.
- stall  in  1  hold current instruction; no retire.
- Instr  out  32  latched instruction.
- op  out  7  Instr[6:0].
- funct3  out  3  Instr[14:12].
- funct7  out  1  Instr[30].
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC + 4 (mod 2^32).
- instr_valid  out  1  Instr valid; retire occurs when instr_valid=1 and stall=0.
- fault  out  1  sticky misaligned-target flag.

## Operation

- FSM states: BOOT, REQ, WAIT, EXEC, FAULT.
- BOOT: entered on reset; imem_req=0; unconditionally -> REQ next cycle.
- REQ: imem_req=1, imem_addr=PC. imem_ready=1 -> WAIT; else stay. Address must not change while waiting for ready.
- WAIT: imem_req=0. imem_rvalid=1 -> Instr<=imem_rdata, -> EXEC; else stay. imem_rvalid in REQ or BOOT is ignored.
- EXEC: instr_valid=1. stall=1 -> stay, Instr/PC unchanged. stall=0 -> retire: next PC = PCSrc ? PC+ImmExt : PC+4 (32-bit wraparound, carry dropped). If PCSrc=1 and target[1:0]!=0 -> FAULT, PC unchanged; else PC<=next PC, -> REQ.
- FAULT: fault=1, instr_valid=0, imem_req=0, Instr=NOP_INSTR; exited only by reset.
- PCSrc and ImmExt are sampled only on a retire cycle; ignored in all other states.
- op/funct3/funct7/PCPlus4 are combinational from Instr/PC registers.
- Reset asserted in any state (including mid-handshake in REQ/WAIT) returns to BOOT immediately; a late imem_rvalid after reset is discarded (BOOT/REQ ignore it).

## Timing

- Reset values: PC=RESET_PC, Instr=NOP_INSTR, instr_valid=0, imem_req=0, fault=0, state=BOOT.
- First request: cycle 1 after rst_n deassert (cycle 0 = BOOT).
- Zero-wait memory (ready in REQ cycle, rvalid in first WAIT cycle): REQ, WAIT, EXEC = 3 cycles per instruction; instr_valid high in cycle 3 after reset release.
- instr_valid is registered: rises the cycle after rvalid accepted; falls the cycle after retire.
- PC updates on the retire edge; imem_addr shows the new PC in the following REQ cycle.
- FAULT entered on the retire edge; fault=1 from the next cycle.
- stall held for N cycles extends EXEC by N cycles; outputs stable throughout.

## Test plan

- Reset release, zero-wait memory, imem_rdata=32'h0010_0093: imem_req at cycle 1, addr 0; instr_valid at cycle 3, op=7'h13, funct3=0; next request addr 4.
- Sequential fetch with imem_ready delayed 2 cycles and rvalid delayed 3: imem_addr held stable, PC sequence 0,4,8, no spurious instr_valid.
- Branch: at PC=32'h10, PCSrc=1, ImmExt=32'hFFFF_FFF8 -> next imem_addr=32'h08; PCSrc=1 with stall=1 ignored until stall drops.
- Wraparound: RESET_PC=32'hFFFF_FFFC, PCSrc=0 -> next PC=0, PCPlus4 of first instr=0.
- Misaligned: PCSrc=1, ImmExt=32'h2 at PC=0 -> fault=1 next cycle, instr_valid=0, imem_req stays 0 until reset.
- Reset in WAIT, then stray imem_rvalid in BOOT -> Instr remains NOP_INSTR, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : RV32I fetch stage (PC, imem handshake, instruction latch)
// Rev 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    input  logic        stall,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        fault_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] next_pc_d;
    logic        misaligned_d;

    assign pc_plus4_d   = pc_q + 32'd4;
    assign next_pc_d    = PCSrc ? (pc_q + ImmExt) : pc_plus4_d;
    // Sequential targets stay aligned; only a taken branch can misalign.
    assign misaligned_d = PCSrc && (next_pc_d[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (misaligned_d) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                            instr_q <= NOP_INSTR;
                        end else begin
                            pc_q    <= next_pc_d;
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                    instr_q <= NOP_INSTR;
                end
                default: begin
                    state_q <= ST_BOOT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4_d;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : randomized memory/decode-side driver with scoreboard
// Rev 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmExt = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        fault;

    instr_fetch_unit #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .stall       (stall),
        .Instr       (Instr),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: architectural PC and memory-side progress.
    logic [31:0] model_pc;
    int          mphase;
    int          mcnt;
    logic        exp_fault;

    // Stimulus knobs
    int unsigned rdy_lo, rdy_hi, rv_lo, rv_hi;
    int unsigned stall_pct, br_pct;
    logic        stray_en;
    logic        fixed_en;
    logic [31:0] fixed_word;
    logic        dir_br;
    int          br_stalls;
    logic        force_en;
    logic [31:0] force_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        PCSrc       = 1'b0;
        exp_q.delete();
        mphase    = 0;
        model_pc  = C_RESET_PC;
        exp_fault = 1'b0;
        dir_br    = 1'b0;
        force_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", PC, C_RESET_PC);
        chk("rst_instr", Instr, C_NOP);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        rst_n = 1'b1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic step();
        int          off;
        logic [31:0] tgt;
        logic [31:0] word;
        @(posedge clk);
        #1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        PCSrc       = 1'($urandom);
        ImmExt      = $urandom;
        stall       = 1'b0;

        if (exp_fault) begin
            chk("fault_flag", {31'b0, fault}, 32'd1);
            chk("fault_valid", {31'b0, instr_valid}, 32'd0);
            chk("fault_req", {31'b0, imem_req}, 32'd0);
            chk("fault_instr", Instr, C_NOP);
            chk("fault_pc", PC, model_pc);
        end else begin
            chk("fault_clear", {31'b0, fault}, 32'd0);
        end

        // Memory side
        if (mphase == 0 && imem_req) begin
            chk("req_addr", imem_addr, model_pc);
            mphase = 1;
            mcnt   = int'($urandom_range(rdy_hi, rdy_lo));
        end else if (mphase == 1) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, model_pc);
        end
        if (mphase == 1) begin
            if (stray_en && $urandom_range(0, 3) == 0)
                imem_rvalid = 1'b1;
            if (mcnt == 0) begin
                imem_ready = 1'b1;
                mphase     = 2;
                mcnt       = int'($urandom_range(rv_hi, rv_lo));
            end else begin
                mcnt--;
            end
        end else if (mphase == 2) begin
            if (mcnt == 0) begin
                word = $urandom;
                if (fixed_en) begin
                    word     = fixed_word;
                    fixed_en = 1'b0;
                end
                imem_rvalid = 1'b1;
                imem_rdata  = word;
                exp_q.push_back('{pc: model_pc, word: word});
                mphase = 0;
            end else begin
                mcnt--;
            end
        end

        // Decode/execute side
        if (instr_valid && !exp_fault) begin
            if (dir_br && model_pc == 32'h10) begin
                if (br_stalls < 2) begin
                    stall  = 1'b1;
                    PCSrc  = 1'b1;
                    ImmExt = 32'h2;
                    br_stalls++;
                end else begin
                    PCSrc  = 1'b1;
                    ImmExt = 32'hFFFF_FFF8;
                    dir_br = 1'b0;
                end
            end else if (force_en) begin
                PCSrc    = 1'b1;
                ImmExt   = force_tgt - model_pc;
                force_en = 1'b0;
            end else begin
                stall = ($urandom_range(0, 99) < stall_pct);
                if (!stall) begin
                    PCSrc = ($urandom_range(0, 99) < br_pct);
                    if (PCSrc) begin
                        off    = int'($urandom_range(0, 127)) - 64;
                        ImmExt = 32'(off * 4);
                    end
                end
            end
            if (!stall) begin
                tgt = PCSrc ? model_pc + ImmExt : model_pc + 32'd4;
                if (PCSrc && tgt[1:0] != 2'b00)
                    exp_fault = 1'b1;
                else
                    model_pc = tgt;
            end
        end
    endtask

    // Monitor: every cycle the DUT presents an instruction it must match the
    // oldest outstanding fetch; it is consumed on the retire cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'b0, instr_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("instr", Instr, e.word);
                    chk("pc", PC, e.pc);
                    chk("pcplus4", PCPlus4, e.pc + 32'd4);
                    chk("op", {25'b0, op}, {25'b0, e.word[6:0]});
                    chk("funct3", {29'b0, funct3}, {29'b0, e.word[14:12]});
                    chk("funct7", {31'b0, funct7}, {31'b0, e.word[30]});
                    if (!stall)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit seen;
        rdy_lo = 0; rdy_hi = 0; rv_lo = 0; rv_hi = 0;
        stall_pct = 0; br_pct = 0; stray_en = 1'b0;
        fixed_en = 1'b0; fixed_word = 32'h0; br_stalls = 0; force_tgt = 32'h0;

        // Zero-wait first fetch timing
        do_reset();
        fixed_en   = 1'b1;
        fixed_word = 32'h0010_0093;
        step();
        chk("req_cycle1", {31'b0, imem_req}, 32'd1);
        chk("addr_cycle1", imem_addr, 32'h0);
        step();
        chk("valid_cycle2", {31'b0, instr_valid}, 32'd0);
        step();
        chk("valid_cycle3", {31'b0, instr_valid}, 32'd1);
        chk("op_cycle3", {25'b0, op}, 32'h13);
        chk("f3_cycle3", {29'b0, funct3}, 32'h0);
        step();
        chk("addr_second", imem_addr, 32'h4);

        // Slow memory, then directed branch with stall at PC 0x10
        rdy_lo = 2; rdy_hi = 2; rv_lo = 3; rv_hi = 3;
        dir_br = 1'b1; br_stalls = 0;
        repeat (80) step();
        chk("branch_seen", {31'b0, dir_br}, 32'd0);

        // Random traffic
        rdy_lo = 0; rdy_hi = 3; rv_lo = 0; rv_hi = 4;
        stall_pct = 30; br_pct = 30; stray_en = 1'b1;
        repeat (3000) step();

        // Wraparound through the top of the address space
        stall_pct = 0; br_pct = 0;
        force_tgt = 32'hFFFF_FFFC; force_en = 1'b1;
        repeat (40) step();

        // Misaligned branch target from PC 0
        do_reset();
        rdy_lo = 0; rdy_hi = 0; rv_lo = 0; rv_hi = 0; stray_en = 1'b0;
        force_tgt = 32'h2; force_en = 1'b1;
        repeat (12) step();
        chk("fault_entered", {31'b0, exp_fault}, 32'd1);

        // Reset while waiting for rvalid, then stray rvalid during BOOT
        do_reset();
        rdy_lo = 1; rdy_hi = 1; rv_lo = 2; rv_hi = 2;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (mphase == 2) seen = 1;
        end
        chk("reach_wait", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mphase = 0;
        model_pc = C_RESET_PC;
        #1;
        chk("midrst_instr", Instr, C_NOP);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        chk("stray_instr", Instr, C_NOP);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, C_RESET_PC);
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
